// File: rtl/vector_exec_ctrl.sv
// Issue/launch/capture controller for a vector execution unit (IDLE/EXEC/WAIT/HOLD).
// Define VEC_EXEC_TIMEOUT_EN to add the WAIT timeout abort and the sticky timeout port.
`ifndef MAX_VLEN
`define MAX_VLEN 128
`endif

module vector_exec_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [2:0]           issue_op,
  output logic [2:0]           exec_op,
  output logic                 exec_start,
  input  logic                 mult_done,
  input  logic                 mac_done,
  input  logic [`MAX_VLEN-1:0] execution_result,
  output logic [`MAX_VLEN-1:0] result_data,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy,
  output logic                 illegal_op,
`ifdef VEC_EXEC_TIMEOUT_EN
  output logic                 timeout,
`endif
  output logic [1:0]           dbg_state
);

  // Handshakes: an instruction transfers on a rising edge where issue_valid & issue_ready;
  // a result transfers on a rising edge where result_valid & result_ready. Neither side may
  // make its valid depend on the other side's ready.

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
    $error("vector_exec_ctrl: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [2:0] OP_ILLEGAL = 3'b010;
  localparam logic [2:0] OP_MULT    = 3'b011;
  localparam logic [2:0] OP_MAC     = 3'b111;

  state_e               state_q, state_d;
  logic [2:0]           exec_op_q, exec_op_d;
  logic                 exec_start_q, exec_start_d;
  logic [`MAX_VLEN-1:0] result_data_q, result_data_d;
  logic                 illegal_q, illegal_d;
  logic                 accept;
  logic                 launch;
  logic                 done_match;

`ifdef VEC_EXEC_TIMEOUT_EN
  localparam logic [7:0] TERM_CNT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  function automatic logic op_is_multi(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MAC);
  endfunction

  // Ready is withheld while reset is asserted so nothing can be offered into a clearing FSM.
  always_comb begin
    issue_ready = 1'b0;
    if (!reset) begin
      issue_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && result_ready);
    end
  end

  assign accept = issue_valid && issue_ready;

  // Only the strobe belonging to the op in flight may complete it.
  always_comb begin
    done_match = 1'b0;
    if (exec_op_q == OP_MULT) begin
      done_match = mult_done;
    end else if (exec_op_q == OP_MAC) begin
      done_match = mac_done;
    end
  end

  always_comb begin
    state_d       = state_q;
    exec_op_d     = exec_op_q;
    exec_start_d  = 1'b0;
    result_data_d = result_data_q;
    illegal_d     = illegal_q;
    launch        = 1'b0;
`ifdef VEC_EXEC_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        launch = accept;
      end
      ST_EXEC: begin
        result_data_d = execution_result;
        state_d       = ST_HOLD;
      end
      ST_WAIT: begin
        if (done_match) begin
          result_data_d = execution_result;
          state_d       = ST_HOLD;
`ifdef VEC_EXEC_TIMEOUT_EN
        end else if (cnt_q == TERM_CNT) begin
          // A done on this same cycle is taken by the branch above instead.
          result_data_d = '1;
          timeout_d     = 1'b1;
          state_d       = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      ST_HOLD: begin
        if (result_ready) begin
          if (accept) begin
            launch = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shared launch path so back-to-back issue from HOLD behaves exactly like issue from IDLE.
    if (launch) begin
      exec_op_d = issue_op;
      if (issue_op == OP_ILLEGAL) begin
        illegal_d     = 1'b1;
        result_data_d = '0;
        state_d       = ST_HOLD;
      end else begin
        exec_start_d = 1'b1;
        if (op_is_multi(issue_op)) begin
          state_d = ST_WAIT;
`ifdef VEC_EXEC_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      exec_op_q     <= 3'd0;
      exec_start_q  <= 1'b0;
      result_data_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      exec_op_q     <= exec_op_d;
      exec_start_q  <= exec_start_d;
      result_data_q <= result_data_d;
      illegal_q     <= illegal_d;
    end
  end

`ifdef VEC_EXEC_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

  assign exec_op      = exec_op_q;
  assign exec_start   = exec_start_q;
  assign result_data  = result_data_q;
  assign result_valid = (state_q == ST_HOLD);
  assign busy         = (state_q != ST_IDLE);
  assign illegal_op   = illegal_q;
  assign dbg_state    = state_q;

endmodule
